scoreboard_ctrl: RTL and testbench

- Register-status scoreboard for the Stage-3 dual-issue pipeline.
- Tracks in-flight destination registers issued by slot0/slot1 and retires them on writeback.
- Tracks which in-flight producers are loads whose data has not yet returned.
- Drives the issue logic's busy_vec/load_pending_vec inputs; supports pipeline flush and reports sticky tracking errors.

---
 rtl/rv32i_pkg.sv | 15 +
 rtl/scoreboard_ctrl_sb_entry.sv | 77 +++++++
 rtl/scoreboard_ctrl.sv | 78 +++++++
 tb/tb_scoreboard_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared scoreboard types and constants for the Stage-3 dual-issue pipeline.
package rv32i_pkg;

  localparam int unsigned NUM_ARCH_REGS = 32;
  localparam int unsigned RD_W          = 5;
  localparam int unsigned SB_CNT_W      = 2;

  // Issue-port event: one register-writing instruction leaving an issue slot.
  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            is_load;
  } sb_evt_t;

endpackage

// File: rtl/scoreboard_ctrl_sb_entry.sv
// One architectural register's in-flight writer counter and load-pending bit.
// Optional feature: SB_WB_BYPASS_EN hides a register in the cycle its last writer retires.
module sb_entry #(
  parameter int unsigned CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] inc,
  input  logic [1:0] dec,
  input  logic       set_ld,
  input  logic       clr_ld,
  input  logic       flush,
  output logic       busy,
  output logic       ld_pend,
  output logic       err
);

  localparam int unsigned SUM_W = CNT_W + 2;
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'((1 << CNT_W) - 1);

  logic [CNT_W-1:0]        count, count_nxt;
  logic                    ld, ld_nxt;
  logic signed [SUM_W-1:0] sum;
  logic                    retire;

  // Next counter/load state with saturation, clamping and flush squash.
  always_comb begin
    count_nxt = count;
    ld_nxt    = ld;
    err       = 1'b0;
    retire    = 1'b0;
    sum       = $signed(SUM_W'(count)) + $signed(SUM_W'(inc)) - $signed(SUM_W'(dec));
    if (flush) begin
      count_nxt = '0;
      ld_nxt    = 1'b0;
    end else begin
      if (sum > MAX_S) begin
        count_nxt = CNT_W'(MAX_S);
        err       = 1'b1;
      end else if (sum < 0) begin
        count_nxt = '0;
        err       = 1'b1;
      end else begin
        count_nxt = CNT_W'(sum);
      end
      // A newer load issuing in the same cycle stays outstanding.
      if (set_ld)
        ld_nxt = 1'b1;
      else if (clr_ld || count_nxt == '0)
        ld_nxt = 1'b0;
      retire = (inc == 2'd0) && (dec != 2'd0) && (count_nxt == '0);
    end
  end

  // Counter and load-bit state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      ld    <= 1'b0;
    end else begin
      count <= count_nxt;
      ld    <= ld_nxt;
    end
  end

  // Status toward the issue logic, optionally bypassing the final writeback.
  always_comb begin
`ifdef SB_WB_BYPASS_EN
    busy    = (count != '0) && !retire;
    ld_pend = ld && !retire;
`else
    busy    = (count != '0);
    ld_pend = ld;
`endif
  end

endmodule

// File: rtl/scoreboard_ctrl.sv
// Register-status scoreboard: tracks in-flight writers and outstanding loads for x1..x31.
// Optional feature: SB_WB_BYPASS_EN (same-cycle writeback visibility on busy/load vectors).
module scoreboard_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned CNT_W = SB_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss0_valid,
  input  logic [RD_W-1:0]          iss0_rd,
  input  logic                     iss0_is_load,
  input  logic                     iss1_valid,
  input  logic [RD_W-1:0]          iss1_rd,
  input  logic                     iss1_is_load,
  input  logic                     wb0_valid,
  input  logic [RD_W-1:0]          wb0_rd,
  input  logic                     wb1_valid,
  input  logic [RD_W-1:0]          wb1_rd,
  input  logic                     ld_done_valid,
  input  logic [RD_W-1:0]          ld_done_rd,
  input  logic                     flush,
  output logic [NUM_ARCH_REGS-1:0] busy_vec,
  output logic [NUM_ARCH_REGS-1:0] load_pending_vec,
  output logic                     sb_err
);

  sb_evt_t                  iss0, iss1;
  logic [NUM_ARCH_REGS-1:0] err_vec;

  assign iss0 = '{valid: iss0_valid, rd: iss0_rd, is_load: iss0_is_load};
  assign iss1 = '{valid: iss1_valid, rd: iss1_rd, is_load: iss1_is_load};

  // x0 is hardwired and never tracked.
  assign busy_vec[0]         = 1'b0;
  assign load_pending_vec[0] = 1'b0;
  assign err_vec[0]          = 1'b0;

  for (genvar r = 1; r < NUM_ARCH_REGS; r++) begin : g_entry
    logic       hit0, hit1, wbh0, wbh1;
    logic [1:0] inc, dec;
    logic       set_ld, clr_ld;

    // Per-register decode of this cycle's issue, writeback and load-return events.
    always_comb begin
      hit0   = iss0.valid && (iss0.rd == RD_W'(r));
      hit1   = iss1.valid && (iss1.rd == RD_W'(r));
      wbh0   = wb0_valid && (wb0_rd == RD_W'(r));
      wbh1   = wb1_valid && (wb1_rd == RD_W'(r));
      inc    = 2'(hit0) + 2'(hit1);
      dec    = 2'(wbh0) + 2'(wbh1);
      set_ld = (hit0 && iss0.is_load) || (hit1 && iss1.is_load);
      clr_ld = ld_done_valid && (ld_done_rd == RD_W'(r));
    end

    sb_entry #(.CNT_W(CNT_W)) u_entry (
      .clk    (clk),
      .rst    (rst),
      .inc    (inc),
      .dec    (dec),
      .set_ld (set_ld),
      .clr_ld (clr_ld),
      .flush  (flush),
      .busy   (busy_vec[r]),
      .ld_pend(load_pending_vec[r]),
      .err    (err_vec[r])
    );
  end

  // Sticky tracking-error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sb_err <= 1'b0;
    else if (|err_vec)
      sb_err <= 1'b1;
  end

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed self-checking bench for scoreboard_ctrl (default CNT_W and a CNT_W=1 copy).
module tb_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss0_valid, iss0_is_load, iss1_valid, iss1_is_load;
  logic [4:0]  iss0_rd, iss1_rd;
  logic        wb0_valid, wb1_valid, ld_done_valid, flush;
  logic [4:0]  wb0_rd, wb1_rd, ld_done_rd;
  logic [31:0] busy_vec, load_pending_vec, busy_vec1, load_pending_vec1;
  logic        sb_err, sb_err1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scoreboard_ctrl u_dut (
    .clk(clk), .rst(rst),
    .iss0_valid(iss0_valid), .iss0_rd(iss0_rd), .iss0_is_load(iss0_is_load),
    .iss1_valid(iss1_valid), .iss1_rd(iss1_rd), .iss1_is_load(iss1_is_load),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb1_valid(wb1_valid), .wb1_rd(wb1_rd),
    .ld_done_valid(ld_done_valid), .ld_done_rd(ld_done_rd), .flush(flush),
    .busy_vec(busy_vec), .load_pending_vec(load_pending_vec), .sb_err(sb_err)
  );

  scoreboard_ctrl #(.CNT_W(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .iss0_valid(iss0_valid), .iss0_rd(iss0_rd), .iss0_is_load(iss0_is_load),
    .iss1_valid(iss1_valid), .iss1_rd(iss1_rd), .iss1_is_load(iss1_is_load),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb1_valid(wb1_valid), .wb1_rd(wb1_rd),
    .ld_done_valid(ld_done_valid), .ld_done_rd(ld_done_rd), .flush(flush),
    .busy_vec(busy_vec1), .load_pending_vec(load_pending_vec1), .sb_err(sb_err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    iss0_valid = 0; iss0_rd = 0; iss0_is_load = 0;
    iss1_valid = 0; iss1_rd = 0; iss1_is_load = 0;
    wb0_valid = 0; wb0_rd = 0; wb1_valid = 0; wb1_rd = 0;
    ld_done_valid = 0; ld_done_rd = 0; flush = 0;
  endtask

  // Commit current inputs on the next edge, then return to idle inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    #2;
    check("reset_busy", busy_vec, 32'h0);
    check("reset_ldp", load_pending_vec, 32'h0);
    check("reset_err", 32'(sb_err), 32'h0);
    @(posedge clk); #1;
    rst = 0;
    tick();

    // Load x5: issue, ld_done, writeback.
    iss0_valid = 1; iss0_rd = 5; iss0_is_load = 1;
    tick();
    check("ld5_c2_busy", busy_vec, 32'h20);
    check("ld5_c2_ldp", load_pending_vec, 32'h20);
    tick();
    check("ld5_c3_busy", busy_vec, 32'h20);
    check("ld5_c3_ldp", load_pending_vec, 32'h20);
    ld_done_valid = 1; ld_done_rd = 5;
    tick();
    check("ld5_c4_busy", busy_vec, 32'h20);
    check("ld5_c4_ldp", load_pending_vec, 32'h0);
    wb0_valid = 1; wb0_rd = 5;
    tick();
    check("ld5_c5_busy", busy_vec, 32'h0);
    check("ld5_err", 32'(sb_err), 32'h0);

    // Dual issue to x7, then dual writeback; CNT_W=1 copy saturates.
    iss0_valid = 1; iss0_rd = 7; iss1_valid = 1; iss1_rd = 7;
    tick();
    check("x7_busy", busy_vec, 32'h80);
    check("x7_sat_busy1", busy_vec1, 32'h80);
    check("x7_sat_err1", 32'(sb_err1), 32'h1);
    check("x7_noerr", 32'(sb_err), 32'h0);
    wb0_valid = 1; wb0_rd = 7; wb1_valid = 1; wb1_rd = 7;
    tick();
    check("x7_retired", busy_vec, 32'h0);
    check("x7_err", 32'(sb_err), 32'h0);

    // Events targeting x0 are ignored.
    iss0_valid = 1; iss0_rd = 0; iss0_is_load = 1;
    iss1_valid = 1; iss1_rd = 0; iss1_is_load = 1;
    tick();
    check("x0_busy", busy_vec, 32'h0);
    check("x0_ldp", load_pending_vec, 32'h0);

    // Flush squashes prior x6 and same-cycle x4 issue.
    iss0_valid = 1; iss0_rd = 6; iss0_is_load = 1;
    tick();
    check("x6_busy", busy_vec, 32'h40);
    iss0_valid = 1; iss0_rd = 4; iss0_is_load = 1; flush = 1;
    tick();
    check("flush_busy", busy_vec, 32'h0);
    check("flush_ldp", load_pending_vec, 32'h0);

    // Last writeback on x8: same-cycle visibility depends on bypass.
    iss0_valid = 1; iss0_rd = 8;
    tick();
    check("x8_busy", busy_vec, 32'h100);
    wb1_valid = 1; wb1_rd = 8;
    #1;
`ifdef SB_WB_BYPASS_EN
    check("x8_wb_cycle", busy_vec, 32'h0);
`else
    check("x8_wb_cycle", busy_vec, 32'h100);
`endif
    tick();
    check("x8_after", busy_vec, 32'h0);

    // Issue and writeback to x10 at count 1 keeps it busy.
    iss0_valid = 1; iss0_rd = 10;
    tick();
    iss0_valid = 1; iss0_rd = 10; wb0_valid = 1; wb0_rd = 10;
    #1;
    check("x10_same_cyc", busy_vec, 32'h400);
    tick();
    check("x10_kept", busy_vec, 32'h400);
    wb0_valid = 1; wb0_rd = 10;
    tick();
    check("x10_done", busy_vec, 32'h0);

    // Underflow on x9 sets sticky error.
    wb0_valid = 1; wb0_rd = 9;
    tick();
    check("x9_busy", busy_vec, 32'h0);
    check("x9_err", 32'(sb_err), 32'h1);
    tick(); tick();
    check("x9_err_sticky", 32'(sb_err), 32'h1);

    // Mid-stream async reset with count[5]=2 and load[5]=1.
    iss0_valid = 1; iss0_rd = 5; iss0_is_load = 1;
    iss1_valid = 1; iss1_rd = 5; iss1_is_load = 1;
    tick();
    check("pre_rst_busy", busy_vec, 32'h20);
    check("pre_rst_ldp", load_pending_vec, 32'h20);
    rst = 1;
    #1;
    check("rst_busy", busy_vec, 32'h0);
    check("rst_ldp", load_pending_vec, 32'h0);
    check("rst_err", 32'(sb_err), 32'h0);
    check("rst_err1", 32'(sb_err1), 32'h0);
    rst = 0;
    tick();
    check("post_rst_busy", busy_vec, 32'h0);
    check("post_rst_err", 32'(sb_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
